// File: rtl/wb_result_arbiter_pkg.sv
// wb_result_arbiter_pkg: shared writeback constants, constant-code encoding and zom mapping.
package wb_result_arbiter_pkg;
  localparam int NSRC_DEF = 7;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam logic [2:0] ZOM_NONE = 3'b000;
  localparam logic [2:0] ZOM_ZERO = 3'b001;
  localparam logic [2:0] ZOM_ONE = 3'b010;
  localparam logic [2:0] ZOM_MONE = 3'b100;
  typedef enum logic [1:0] {
    CONST_ZERO = 2'd0,
    CONST_ONE  = 2'd1,
    CONST_MONE = 2'd2,
    CONST_ILL  = 2'd3
  } const_code_e;
  // The illegal code falls back to writing zero.
  function automatic logic [2:0] zom_of(input logic [1:0] code);
    return code == CONST_ONE ? ZOM_ONE : code == CONST_MONE ? ZOM_MONE : ZOM_ZERO;
  endfunction
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational round-robin first-one finder starting at ptr.
module wb_rr_pick #(
  parameter int N = 7,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [PW-1:0] c;
  always_comb begin
    idx = '0;
    any = 1'b0;
    c = '0;
    for (int k = 0; k < N; k++) begin
      c = PW'((int'(ptr) + k) % N);
      if (!any && req[c]) begin
        idx = c;
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter: arbitrates completions onto the writeback mux and a registered GPR write port.
module wb_result_arbiter
  import wb_result_arbiter_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  src_valid,
  input  logic [NSRC*AW-1:0] src_tgt,
  output logic [NSRC-1:0]  src_ready,
  input  logic             const_valid,
  input  logic [1:0]       const_code,
  input  logic [AW-1:0]    const_tgt,
  output logic             const_ready,
  output logic [NSRC-1:0]  sel,
  output logic [2:0]       zom,
  input  logic [DW-1:0]    mux_result,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [DW-1:0]    wb_data,
  input  logic             wb_ready,
  output logic             const_err
);
  localparam int PW = $clog2(NSRC);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [PW-1:0] rr_ptr;
  logic [SW-1:0] starve_cnt;
  logic [NSRC-1:0] gnt;
  logic [PW-1:0] idx;
  logic any, slot_free, starved, gc, gs;
  wb_rr_pick #(.N(NSRC), .PW(PW)) u_pick (
    .req(src_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  // Reset gates the grant path so the mux stays quiet during reset.
  always_comb begin
    slot_free = !reset && (!wb_valid || wb_ready);
    starved = const_valid && starve_cnt >= SW'(STARVE_LIMIT);
    gc = slot_free && const_valid && (starved || !any);
    gs = slot_free && !gc && any;
    src_ready = gs ? gnt : '0;
    sel = src_ready;
    const_ready = gc;
    zom = gc ? zom_of(const_code) : ZOM_NONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      const_err <= 1'b0;
      rr_ptr <= '0;
      starve_cnt <= '0;
    end else begin
      const_err <= gc && const_code == CONST_ILL;
      if (gs || gc) begin
        wb_valid <= 1'b1;
        wb_data <= mux_result;
        wb_addr <= gc ? const_tgt : src_tgt[int'(idx)*AW +: AW];
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
      if (gs) rr_ptr <= idx == PW'(NSRC - 1) ? '0 : idx + 1'b1;
      starve_cnt <= (!const_valid || gc) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
    end
  end
  a_sel_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(sel));
  a_sel_zom: assert property (@(posedge clk) disable iff (reset) sel != '0 |-> zom == ZOM_NONE);
  a_one_ready: assert property (@(posedge clk) disable iff (reset) $onehot0({src_ready, const_ready}));
endmodule

// File: tb/tb_wb_result_arbiter.sv
// tb_wb_result_arbiter: table vectors, directed corner sequences and randomized model checks.
module tb_wb_result_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] src_valid = '0;
  logic [34:0] src_tgt = '0;
  logic [6:0] src_ready;
  logic const_valid = 1'b0;
  logic [1:0] const_code = '0;
  logic [4:0] const_tgt = '0;
  logic const_ready;
  logic [6:0] sel;
  logic [2:0] zom;
  logic [31:0] mux_result;
  logic wb_valid;
  logic [4:0] wb_addr;
  logic [31:0] wb_data;
  logic wb_ready = 1'b1;
  logic const_err;
  logic [31:0] src_data [7];
  logic use_mux = 1'b1;
  logic [31:0] fixed = '0;
  int checks = 0;
  int errors = 0;
  int m_ptr, m_cnt, last_g;
  bit m_v, m_err, last_gc;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  typedef struct {
    logic [6:0] sv;
    logic cv;
    logic [1:0] code;
    logic [6:0] esel;
    logic [2:0] ezom;
    logic ecr;
    logic [31:0] ed;
    logic eerr;
  } vec_t;
  vec_t vt[9];
  wb_result_arbiter dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_tgt(src_tgt), .src_ready(src_ready),
    .const_valid(const_valid), .const_code(const_code), .const_tgt(const_tgt), .const_ready(const_ready),
    .sel(sel), .zom(zom), .mux_result(mux_result), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_ready(wb_ready), .const_err(const_err)
  );
  always #5 clk = ~clk;
  always_comb begin
    mux_result = fixed;
    if (use_mux) begin
      mux_result = zom == 3'b010 ? 32'h1 : zom == 3'b100 ? 32'hFFFF_FFFF : 32'h0;
      for (int i = 0; i < 7; i++) if (sel[i]) mux_result = src_data[i];
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic apply(input logic [6:0] sv, input logic cv, input logic [1:0] code, input logic rdy);
    src_valid = sv;
    const_valid = cv;
    const_code = code;
    wb_ready = rdy;
  endtask
  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_v = 0; m_err = 0; m_addr = '0; m_data = '0;
  endtask
  task automatic do_reset();
    apply(7'h7F, 1'b1, 2'd1, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_const_err", const_err, 0);
    chk("rst_sel", sel, 0);
    chk("rst_ready", {src_ready, const_ready}, 0);
    chk("rst_zom", zom, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic cycle();
    int g;
    bit gc, free, cv, rdy;
    logic [1:0] code;
    logic [6:0] es;
    logic [2:0] ez;
    logic [31:0] ed;
    logic [4:0] ea;
    #2;
    cv = const_valid; rdy = wb_ready; code = const_code;
    free = !m_v || rdy;
    g = -1; gc = 0; ed = '0; ea = '0;
    if (free) begin
      if (cv && m_cnt >= 8) gc = 1;
      else begin
        for (int k = 0; k < 7; k++) if (g < 0 && src_valid[(m_ptr + k) % 7]) g = (m_ptr + k) % 7;
        if (g < 0 && cv) gc = 1;
      end
    end
    es = g >= 0 ? 7'(1 << g) : 7'd0;
    ez = !gc ? 3'b000 : code == 2'd1 ? 3'b010 : code == 2'd2 ? 3'b100 : 3'b001;
    chk("sel", sel, es);
    chk("src_ready", src_ready, es);
    chk("const_ready", const_ready, gc);
    chk("zom", zom, ez);
    last_g = g; last_gc = gc;
    if (gc) begin
      ed = !use_mux ? fixed : code == 2'd1 ? 32'h1 : code == 2'd2 ? 32'hFFFF_FFFF : 32'h0;
      ea = const_tgt;
    end else if (g >= 0) begin
      ed = use_mux ? src_data[g] : fixed;
      ea = src_tgt[g*5 +: 5];
    end
    @(posedge clk);
    if (g >= 0 || gc) begin
      m_v = 1; m_addr = ea; m_data = ed;
    end else if (rdy) m_v = 0;
    if (g >= 0) m_ptr = (g + 1) % 7;
    m_err = gc && code == 2'd3;
    m_cnt = (!cv || gc) ? 0 : (m_cnt < 8 ? m_cnt + 1 : 8);
    #1;
    chk("wb_valid", wb_valid, m_v);
    chk("wb_addr", wb_addr, m_addr);
    chk("wb_data", wb_data, m_data);
    chk("const_err", const_err, m_err);
  endtask
  initial begin
    logic [4:0] ha;
    logic [31:0] hd;
    int found;
    for (int i = 0; i < 7; i++) src_data[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 7; i++) src_tgt[i*5 +: 5] = 5'(i + 8);
    const_tgt = 5'd30;
    vt[0] = '{7'b0000100, 1'b0, 2'd0, 7'b0000100, 3'b000, 1'b0, 32'h1000_0002, 1'b0};
    vt[1] = '{7'b1111111, 1'b0, 2'd0, 7'b0001000, 3'b000, 1'b0, 32'h1000_0003, 1'b0};
    vt[2] = '{7'b0000011, 1'b0, 2'd0, 7'b0000001, 3'b000, 1'b0, 32'h1000_0000, 1'b0};
    vt[3] = '{7'b0000000, 1'b1, 2'd1, 7'b0000000, 3'b010, 1'b1, 32'h0000_0001, 1'b0};
    vt[4] = '{7'b0000000, 1'b1, 2'd2, 7'b0000000, 3'b100, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vt[5] = '{7'b0000000, 1'b1, 2'd0, 7'b0000000, 3'b001, 1'b1, 32'h0000_0000, 1'b0};
    vt[6] = '{7'b0000000, 1'b1, 2'd3, 7'b0000000, 3'b001, 1'b1, 32'h0000_0000, 1'b1};
    vt[7] = '{7'b0000001, 1'b1, 2'd1, 7'b0000001, 3'b000, 1'b0, 32'h1000_0000, 1'b0};
    vt[8] = '{7'b0000000, 1'b0, 2'd0, 7'b0000000, 3'b000, 1'b0, 32'h1000_0000, 1'b0};
    do_reset();
    use_mux = 1'b0; fixed = 32'hDEAD_BEEF; src_tgt[10 +: 5] = 5'd7;
    apply(7'b0000100, 1'b0, 2'd0, 1'b1);
    #1 chk("single_sel", sel, 7'b0000100);
    chk("single_zom", zom, 3'b000);
    cycle();
    chk("single_valid", wb_valid, 1);
    chk("single_addr", wb_addr, 7);
    chk("single_data", wb_data, 32'hDEAD_BEEF);
    use_mux = 1'b1;
    do_reset();
    foreach (vt[i]) begin
      apply(vt[i].sv, vt[i].cv, vt[i].code, 1'b1);
      #1;
      chk($sformatf("vec%0d_sel", i), sel, vt[i].esel);
      chk($sformatf("vec%0d_zom", i), zom, vt[i].ezom);
      chk($sformatf("vec%0d_cr", i), const_ready, vt[i].ecr);
      cycle();
      chk($sformatf("vec%0d_data", i), wb_data, vt[i].ed);
      chk($sformatf("vec%0d_err", i), const_err, vt[i].eerr);
    end
    do_reset();
    apply(7'h7F, 1'b0, 2'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_order", last_g, k % 7);
    end
    do_reset();
    apply(7'h7F, 1'b1, 2'd2, 1'b1);
    found = -1;
    for (int k = 0; k < 12 && found < 0; k++) begin
      cycle();
      if (last_gc) found = k;
    end
    chk("starve_at", found, 8);
    cycle();
    chk("after_starve", last_g, 1);
    do_reset();
    apply(7'b0000001, 1'b0, 2'd0, 1'b1);
    cycle();
    ha = wb_addr; hd = wb_data;
    apply(7'h7F, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_ready", {src_ready, const_ready}, 0);
      chk("stall_addr", wb_addr, ha);
      chk("stall_data", wb_data, hd);
    end
    wb_ready = 1'b1;
    cycle();
    chk("overwrite_src", last_g, 1);
    chk("overwrite_valid", wb_valid, 1);
    chk("overwrite_data", wb_data, src_data[1]);
    wb_ready = 1'b0;
    cycle();
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", wb_valid, 0);
    chk("async_rst_sel", sel, 0);
    chk("async_rst_ready", {src_ready, const_ready}, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    apply(7'h7F, 1'b0, 2'd0, 1'b1);
    cycle();
    chk("post_rst_src0", last_g, 0);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 7; i++) src_data[i] = $urandom;
      src_tgt = 35'({$urandom, $urandom});
      const_tgt = 5'($urandom);
      apply(7'($urandom & $urandom), 1'($urandom_range(0, 1)), 2'($urandom), $urandom_range(0, 3) != 0);
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
